// File: rtl/frame_track_pkg.sv
// -----------------------------------------------------------------------------
// frame_track_pkg
// Shared definitions for the frame_track stream-front stage and the
// downstream delay_mem block.
//   DEF_IMG_WIDTH : default pixel data width in bits
//   DEF_DIM_WIDTH : default geometry/counter width (equals delay_mem MEM_AWIDTH)
//   state_t       : controller state encoding (ST_IDLE, ST_RUN)
// -----------------------------------------------------------------------------
package frame_track_pkg;

    localparam int DEF_IMG_WIDTH = 8;
    localparam int DEF_DIM_WIDTH = 8;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/frame_track_if.sv
// -----------------------------------------------------------------------------
// frame_track_if
// Bundles the configuration, upstream pixel, downstream pixel and delay_mem
// configuration signals of frame_track.
//   cfg_width/cfg_height/cfg_set : geometry configuration strobe
//   up_data/up_val               : incoming pixel stream (no backpressure)
//   dn_data/dn_val/dn_sol/dn_eol/dn_sof/dn_eof : tagged pixel stream
//   dly_delay/dly_set            : line-length programming for delay_mem
// Modports:
//   master : the side driving config and upstream pixels
//   slave  : frame_track itself
// -----------------------------------------------------------------------------
interface frame_track_if
    import frame_track_pkg::*;
#(
    parameter int IMG_WIDTH = DEF_IMG_WIDTH,
    parameter int DIM_WIDTH = DEF_DIM_WIDTH
) ();

    logic [DIM_WIDTH-1:0] cfg_width;
    logic [DIM_WIDTH-1:0] cfg_height;
    logic                 cfg_set;

    logic [IMG_WIDTH-1:0] up_data;
    logic                 up_val;

    logic [IMG_WIDTH-1:0] dn_data;
    logic                 dn_val;
    logic                 dn_sol;
    logic                 dn_eol;
    logic                 dn_sof;
    logic                 dn_eof;

    logic [DIM_WIDTH-1:0] dly_delay;
    logic                 dly_set;

    modport master (
        output cfg_width, cfg_height, cfg_set,
        output up_data, up_val,
        input  dn_data, dn_val, dn_sol, dn_eol, dn_sof, dn_eof,
        input  dly_delay, dly_set
    );

    modport slave (
        input  cfg_width, cfg_height, cfg_set,
        input  up_data, up_val,
        output dn_data, dn_val, dn_sol, dn_eol, dn_sof, dn_eof,
        output dly_delay, dly_set
    );

endinterface

// File: rtl/frame_pos_cnt.sv
// -----------------------------------------------------------------------------
// frame_pos_cnt
// Column/row position counters for frame_track. Advances once per accepted
// pixel, wraps the column at width-1 and the row at height-1, and reports the
// position flags of the pixel currently being accepted.
// Ports:
//   clk, rst            : clock, asynchronous active-high reset
//   i_adv               : pixel accepted this cycle
//   i_width, i_height   : active geometry (both >= 1 whenever i_adv is set)
//   o_sol/o_eol         : current column is first/last of the line
//   o_sof/o_eof         : current pixel is first/last of the frame
//   o_origin            : counters sit at column 0, row 0
// -----------------------------------------------------------------------------
module frame_pos_cnt #(
    parameter int DIM_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_adv,
    input  logic [DIM_WIDTH-1:0] i_width,
    input  logic [DIM_WIDTH-1:0] i_height,
    output logic                 o_sol,
    output logic                 o_eol,
    output logic                 o_sof,
    output logic                 o_eof,
    output logic                 o_origin
);

    localparam logic [DIM_WIDTH-1:0] DIM_ONE = {{(DIM_WIDTH-1){1'b0}}, 1'b1};

    logic [DIM_WIDTH-1:0] r_col;
    logic [DIM_WIDTH-1:0] r_row;
    logic [DIM_WIDTH-1:0] w_col_last;
    logic [DIM_WIDTH-1:0] w_row_last;
    logic                 w_col_first;
    logic                 w_row_first;
    logic                 w_at_col_last;
    logic                 w_at_row_last;

    assign w_col_last    = i_width - DIM_ONE;
    assign w_row_last    = i_height - DIM_ONE;
    assign w_col_first   = (r_col == '0);
    assign w_row_first   = (r_row == '0);
    assign w_at_col_last = (r_col == w_col_last);
    assign w_at_row_last = (r_row == w_row_last);

    // With width 1 the first and last column coincide, so sol and eol
    // both fire on every pixel without special handling.
    assign o_sol    = w_col_first;
    assign o_eol    = w_at_col_last;
    assign o_sof    = w_col_first & w_row_first;
    assign o_eof    = w_at_col_last & w_at_row_last;
    assign o_origin = w_col_first & w_row_first;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_col <= '0;
            r_row <= '0;
        end else if (i_adv) begin
            if (w_at_col_last) begin
                r_col <= '0;
                r_row <= w_at_row_last ? '0 : (r_row + DIM_ONE);
            end else begin
                r_col <= r_col + DIM_ONE;
            end
        end
    end

endmodule

// File: rtl/frame_track.sv
// -----------------------------------------------------------------------------
// frame_track
// Stream-front stage ahead of delay_mem. Tags each accepted pixel with
// sol/eol/sof/eof from the active frame geometry, forwards it one cycle
// later, and programs delay_mem with the line length whenever a new
// geometry takes effect. Geometry changes requested mid-frame are held in a
// shadow register and take effect on the edge accepting the eof pixel.
// Ports:
//   clk, rst : clock, asynchronous active-high reset
//   bus      : frame_track_if.slave (config, upstream, downstream, delay cfg)
//   stat_frames, stat_drops : only with FRAME_TRACK_STATS_EN defined;
//              eof pixel count (wrapping) and IDLE drop count (saturating)
// Build option: define FRAME_TRACK_STATS_EN to add the statistics counters.
//
// State table
//   state   | meaning
//   --------+-------------------------------------------------------------
//   ST_IDLE | no valid geometry yet; upstream pixels are dropped
//   ST_RUN  | pixels are accepted, tagged and forwarded
// -----------------------------------------------------------------------------
module frame_track
    import frame_track_pkg::*;
#(
    parameter int IMG_WIDTH = DEF_IMG_WIDTH,
    parameter int DIM_WIDTH = DEF_DIM_WIDTH
) (
    input  logic         clk,
    input  logic         rst,
    frame_track_if.slave bus
`ifdef FRAME_TRACK_STATS_EN
    ,
    output logic [15:0]  stat_frames,
    output logic [15:0]  stat_drops
`endif
);

    state_t               r_state;
    state_t               w_state_nxt;

    logic [DIM_WIDTH-1:0] r_act_w;
    logic [DIM_WIDTH-1:0] r_act_h;
    logic                 r_pend_vld;
    logic [DIM_WIDTH-1:0] r_pend_w;
    logic [DIM_WIDTH-1:0] r_pend_h;

    logic [DIM_WIDTH-1:0] r_dly_delay;
    logic                 r_dly_set;

    logic [IMG_WIDTH-1:0] r_dn_data;
    logic                 r_dn_val;
    logic                 r_dn_sol;
    logic                 r_dn_eol;
    logic                 r_dn_sof;
    logic                 r_dn_eof;

    logic                 w_cfg_ok;
    logic                 w_accept;
    logic                 w_apply;
    logic                 w_apply_pend;
    logic                 w_pend_load;
    logic                 w_pend_clr;
    logic [DIM_WIDTH-1:0] w_new_w;
    logic [DIM_WIDTH-1:0] w_new_h;

    logic                 w_pos_sol;
    logic                 w_pos_eol;
    logic                 w_pos_sof;
    logic                 w_pos_eof;
    logic                 w_origin;

    // A zero dimension would make the wrap compares meaningless, so such a
    // request is treated as if no strobe had arrived.
    assign w_cfg_ok = bus.cfg_set && (bus.cfg_width != '0) && (bus.cfg_height != '0);

    frame_pos_cnt #(
        .DIM_WIDTH (DIM_WIDTH)
    ) u_pos (
        .clk      (clk),
        .rst      (rst),
        .i_adv    (w_accept),
        .i_width  (r_act_w),
        .i_height (r_act_h),
        .o_sol    (w_pos_sol),
        .o_eol    (w_pos_eol),
        .o_sof    (w_pos_sof),
        .o_eof    (w_pos_eof),
        .o_origin (w_origin)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_accept     = 1'b0;
        w_apply      = 1'b0;
        w_apply_pend = 1'b0;
        w_pend_load  = 1'b0;
        w_pend_clr   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_cfg_ok) begin
                    w_apply     = 1'b1;
                    w_state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                w_accept = bus.up_val;
                if (bus.up_val && w_pos_eof) begin
                    // The eof pixel is tagged with the old geometry; a strobe
                    // on this very edge beats anything already shadowed.
                    w_pend_clr = 1'b1;
                    if (w_cfg_ok) begin
                        w_apply = 1'b1;
                    end else if (r_pend_vld) begin
                        w_apply      = 1'b1;
                        w_apply_pend = 1'b1;
                    end
                end else if (w_cfg_ok) begin
                    if (w_origin && !bus.up_val) begin
                        w_apply    = 1'b1;
                        w_pend_clr = 1'b1;
                    end else begin
                        w_pend_load = 1'b1;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign w_new_w = w_apply_pend ? r_pend_w : bus.cfg_width;
    assign w_new_h = w_apply_pend ? r_pend_h : bus.cfg_height;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_act_w     <= '0;
            r_act_h     <= '0;
            r_pend_vld  <= 1'b0;
            r_pend_w    <= '0;
            r_pend_h    <= '0;
            r_dly_delay <= '0;
            r_dly_set   <= 1'b0;
        end else begin
            r_dly_set <= w_apply;
            if (w_apply) begin
                r_act_w     <= w_new_w;
                r_act_h     <= w_new_h;
                r_dly_delay <= w_new_w;
            end
            if (w_pend_load) begin
                r_pend_vld <= 1'b1;
                r_pend_w   <= bus.cfg_width;
                r_pend_h   <= bus.cfg_height;
            end else if (w_pend_clr) begin
                r_pend_vld <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_dn_data <= '0;
            r_dn_val  <= 1'b0;
            r_dn_sol  <= 1'b0;
            r_dn_eol  <= 1'b0;
            r_dn_sof  <= 1'b0;
            r_dn_eof  <= 1'b0;
        end else begin
            r_dn_val <= w_accept;
            if (w_accept) begin
                r_dn_data <= bus.up_data;
                r_dn_sol  <= w_pos_sol;
                r_dn_eol  <= w_pos_eol;
                r_dn_sof  <= w_pos_sof;
                r_dn_eof  <= w_pos_eof;
            end else begin
                r_dn_sol  <= 1'b0;
                r_dn_eol  <= 1'b0;
                r_dn_sof  <= 1'b0;
                r_dn_eof  <= 1'b0;
            end
        end
    end

    assign bus.dn_data   = r_dn_data;
    assign bus.dn_val    = r_dn_val;
    assign bus.dn_sol    = r_dn_sol;
    assign bus.dn_eol    = r_dn_eol;
    assign bus.dn_sof    = r_dn_sof;
    assign bus.dn_eof    = r_dn_eof;
    assign bus.dly_delay = r_dly_delay;
    assign bus.dly_set   = r_dly_set;

`ifdef FRAME_TRACK_STATS_EN
    logic [15:0] r_stat_frames;
    logic [15:0] r_stat_drops;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stat_frames <= '0;
            r_stat_drops  <= '0;
        end else begin
            if (w_accept && w_pos_eof) begin
                r_stat_frames <= r_stat_frames + 16'd1;
            end
            if ((r_state == ST_IDLE) && bus.up_val && (r_stat_drops != 16'hFFFF)) begin
                r_stat_drops <= r_stat_drops + 16'd1;
            end
        end
    end

    assign stat_frames = r_stat_frames;
    assign stat_drops  = r_stat_drops;
`endif

endmodule

// File: tb/tb_frame_track.sv
module tb_frame_track;
    import frame_track_pkg::*;

    localparam int IW = DEF_IMG_WIDTH;
    localparam int DW = DEF_DIM_WIDTH;

    logic clk = 1'b0;
    logic rst = 1'b1;

    frame_track_if #(.IMG_WIDTH(IW), .DIM_WIDTH(DW)) bus ();

`ifdef FRAME_TRACK_STATS_EN
    logic [15:0] stat_frames;
    logic [15:0] stat_drops;
`endif

    frame_track #(.IMG_WIDTH(IW), .DIM_WIDTH(DW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
`ifdef FRAME_TRACK_STATS_EN
        ,
        .stat_frames (stat_frames),
        .stat_drops  (stat_drops)
`endif
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference model: position is a linear pixel index inside the frame.
    bit       m_run;
    int       m_W, m_H, m_p;
    bit       m_pend;
    int       m_pw, m_ph;
    int       m_frames, m_drops;
    bit       e_val, e_sol, e_eol, e_sof, e_eof, e_dset;
    logic [7:0] e_delay, e_data;

    logic [21:0] obs;
    assign obs = {bus.dn_val, bus.dn_sol, bus.dn_eol, bus.dn_sof, bus.dn_eof,
                  bus.dly_set, bus.dly_delay, bus.dn_data};

    function automatic logic [21:0] exp_vec();
        return {e_val, e_sol, e_eol, e_sof, e_eof, e_dset, e_delay, e_data};
    endfunction

    task automatic model_reset();
        m_run = 0; m_W = 0; m_H = 0; m_p = 0; m_pend = 0; m_pw = 0; m_ph = 0;
        m_frames = 0; m_drops = 0;
        e_val = 0; e_sol = 0; e_eol = 0; e_sof = 0; e_eof = 0; e_dset = 0;
        e_delay = 8'd0; e_data = 8'd0;
    endtask

    task automatic model_apply(input int w, input int h);
        m_W = w; m_H = h; m_p = 0;
        e_dset = 1; e_delay = w[7:0];
    endtask

    // Drive one cycle of inputs, advance the model, then wait to 1ns past the edge.
    task automatic step(input bit cs, input int w, input int h, input bit v, input int d);
        bit ok;
        bit is_eof;
        bus.cfg_set    = cs;
        bus.cfg_width  = w[7:0];
        bus.cfg_height = h[7:0];
        bus.up_val     = v;
        bus.up_data    = d[7:0];
        ok = cs && (w != 0) && (h != 0);
        e_dset = 0; e_val = 0; e_sol = 0; e_eol = 0; e_sof = 0; e_eof = 0;
        if (!m_run) begin
            if (v && m_drops < 65535) m_drops++;
            if (ok) begin
                model_apply(w, h);
                m_run = 1;
            end
        end else begin
            is_eof = 0;
            if (v) begin
                e_val  = 1;
                e_data = d[7:0];
                e_sol  = (m_p % m_W) == 0;
                e_eol  = (m_p % m_W) == (m_W - 1);
                e_sof  = (m_p == 0);
                e_eof  = (m_p == m_W * m_H - 1);
                is_eof = e_eof;
                if (is_eof) begin
                    m_p = 0;
                    m_frames = (m_frames + 1) % 65536;
                end else begin
                    m_p++;
                end
            end
            if (is_eof) begin
                if (ok) model_apply(w, h);
                else if (m_pend) model_apply(m_pw, m_ph);
                m_pend = 0;
            end else if (ok) begin
                if (m_p == 0 && !v) begin
                    model_apply(w, h);
                    m_pend = 0;
                end else begin
                    m_pend = 1; m_pw = w; m_ph = h;
                end
            end
        end
        @(posedge clk);
        #1;
        bus.cfg_set = 1'b0;
        bus.up_val  = 1'b0;
    endtask

    task automatic test_reset();
        model_reset();
        #12;
        if (obs !== 22'd0) begin
            failures++;
            $display("FAIL reset_hold obs=%h exp=%h", obs, 22'd0);
        end
        checks++;
        rst = 1'b0;
        @(posedge clk);
        #1;
        if (obs !== exp_vec()) begin
            failures++;
            $display("FAIL reset_release obs=%h exp=%h", obs, exp_vec());
        end
        checks++;
    endtask

    task automatic test_no_cfg();
        int seen;
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            step(0, 0, 0, 1, $urandom);
            if (bus.dn_val || bus.dly_set) seen++;
            if (obs !== exp_vec()) begin
                failures++;
                $display("FAIL no_cfg cyc%0d obs=%h exp=%h", i, obs, exp_vec());
            end
            checks++;
        end
        if (seen !== 0) begin
            failures++;
            $display("FAIL no_cfg_activity got=%0d want=0", seen);
        end
        checks++;
`ifdef FRAME_TRACK_STATS_EN
        if (stat_drops !== 16'd10) begin
            failures++;
            $display("FAIL no_cfg_drops got=%0d want=10", stat_drops);
        end
        checks++;
`endif
    endtask

    task automatic test_frame_4x3();
        logic [11:0] sol_m, eol_m, sof_m, eof_m;
        int pulses;
        sol_m = '0; eol_m = '0; sof_m = '0; eof_m = '0;
        step(1, 4, 3, 0, 0);
        pulses = bus.dly_set ? 1 : 0;
        if (obs !== exp_vec()) begin
            failures++;
            $display("FAIL f4x3_cfg obs=%h exp=%h", obs, exp_vec());
        end
        checks++;
        for (int i = 0; i < 12; i++) begin
            step(0, 0, 0, 1, i + 1);
            if (bus.dly_set) pulses++;
            sol_m[i] = bus.dn_sol; eol_m[i] = bus.dn_eol;
            sof_m[i] = bus.dn_sof; eof_m[i] = bus.dn_eof;
            if (obs !== exp_vec()) begin
                failures++;
                $display("FAIL f4x3 px%0d obs=%h exp=%h", i + 1, obs, exp_vec());
            end
            checks++;
        end
        if ({sol_m, eol_m, sof_m, eof_m} !== {12'h111, 12'h888, 12'h001, 12'h800}) begin
            failures++;
            $display("FAIL f4x3_flags got=%h_%h_%h_%h want=111_888_001_800", sol_m, eol_m, sof_m, eof_m);
        end
        checks++;
        if (pulses !== 1 || bus.dly_delay !== 8'd4) begin
            failures++;
            $display("FAIL f4x3_dly pulses=%0d delay=%0d want 1/4", pulses, bus.dly_delay);
        end
        checks++;
    endtask

    task automatic test_gaps();
        int px, nsof, neof, cyc;
        px = 0; nsof = 0; neof = 0; cyc = 0;
        while (px < 24 && cyc < 100) begin
            if (cyc % 3 != 2) begin
                px++;
                step(0, 0, 0, 1, $urandom);
            end else begin
                step(0, 0, 0, 0, $urandom);
            end
            if (bus.dn_sof) nsof++;
            if (bus.dn_eof) neof++;
            if (obs !== exp_vec()) begin
                failures++;
                $display("FAIL gaps cyc%0d obs=%h exp=%h", cyc, obs, exp_vec());
            end
            checks++;
            cyc++;
        end
        if (nsof !== 2 || neof !== 2) begin
            failures++;
            $display("FAIL gaps_count sof=%0d eof=%0d want 2/2", nsof, neof);
        end
        checks++;
    endtask

    task automatic test_midframe_cfg();
        for (int i = 0; i < 17; i++) begin
            if (i == 5) step(1, 2, 2, 0, 0);
            step(0, 0, 0, 1, i + 1);
            if (obs !== exp_vec()) begin
                failures++;
                $display("FAIL midframe px%0d obs=%h exp=%h", i + 1, obs, exp_vec());
            end
            checks++;
            if (i == 11 && (bus.dly_set !== 1'b1 || bus.dly_delay !== 8'd2 || bus.dn_eof !== 1'b1)) begin
                failures++;
                $display("FAIL midframe_apply set=%b delay=%0d eof=%b want 1/2/1", bus.dly_set, bus.dly_delay, bus.dn_eof);
            end
            if (i == 11) checks++;
        end
    endtask

    task automatic test_zero_cfg();
        int pulses;
        pulses = 0;
        step(1, 0, 3, 0, 0);
        if (bus.dly_set) pulses++;
        step(1, 5, 0, 1, 8'h5A);
        if (bus.dly_set) pulses++;
        for (int i = 0; i < 6; i++) begin
            step(0, 0, 0, 1, $urandom);
            if (bus.dly_set) pulses++;
            if (obs !== exp_vec()) begin
                failures++;
                $display("FAIL zero_cfg cyc%0d obs=%h exp=%h", i, obs, exp_vec());
            end
            checks++;
        end
        if (pulses !== 0 || bus.dly_delay !== 8'd2) begin
            failures++;
            $display("FAIL zero_cfg_ignored pulses=%0d delay=%0d want 0/2", pulses, bus.dly_delay);
        end
        checks++;
    endtask

    task automatic test_reset_midframe();
        while (m_p != 0) step(0, 0, 0, 1, $urandom);
        step(1, 4, 3, 0, 0);
        for (int i = 0; i < 7; i++) step(0, 0, 0, 1, i + 1);
        #1;
        rst = 1'b1;
        #1;
        model_reset();
        if (bus.dn_val !== 1'b0 || obs !== 22'd0) begin
            failures++;
            $display("FAIL rst_async dn_val=%b obs=%h exp=0", bus.dn_val, obs);
        end
        checks++;
`ifdef FRAME_TRACK_STATS_EN
        if (stat_frames !== 16'd0 || stat_drops !== 16'd0) begin
            failures++;
            $display("FAIL rst_stats frames=%0d drops=%0d want 0/0", stat_frames, stat_drops);
        end
        checks++;
`endif
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step(0, 0, 0, 1, $urandom);
            if (obs !== exp_vec()) begin
                failures++;
                $display("FAIL post_rst_drop cyc%0d obs=%h exp=%h", i, obs, exp_vec());
            end
            checks++;
        end
    endtask

    // 3x2 geometry, mid-frame request shadowed, then a newer request on the eof edge wins.
    task automatic test_same_edge();
        step(1, 3, 2, 0, 0);
        for (int i = 0; i < 10; i++) begin
            if (i == 2)      step(1, 2, 1, 1, i + 1);
            else if (i == 5) step(1, 4, 1, 1, i + 1);
            else             step(0, 0, 0, 1, i + 1);
            if (obs !== exp_vec()) begin
                failures++;
                $display("FAIL same_edge px%0d obs=%h exp=%h", i + 1, obs, exp_vec());
            end
            checks++;
            if (i == 5 && (bus.dly_delay !== 8'd4 || bus.dn_eof !== 1'b1)) begin
                failures++;
                $display("FAIL same_edge_newest delay=%0d eof=%b want 4/1", bus.dly_delay, bus.dn_eof);
            end
            if (i == 5) checks++;
        end
    endtask

    task automatic test_random();
        bit cs, v;
        int w, h;
        for (int i = 0; i < 800; i++) begin
            cs = ($urandom % 8) == 0;
            w  = $urandom_range(0, 4);
            h  = $urandom_range(0, 3);
            v  = ($urandom % 4) != 0;
            step(cs, w, h, v, $urandom);
            if (obs !== exp_vec()) begin
                failures++;
                $display("FAIL random cyc%0d obs=%h exp=%h", i, obs, exp_vec());
            end
            checks++;
        end
`ifdef FRAME_TRACK_STATS_EN
        if (stat_frames !== m_frames[15:0] || stat_drops !== m_drops[15:0]) begin
            failures++;
            $display("FAIL random_stats frames=%0d/%0d drops=%0d/%0d", stat_frames, m_frames, stat_drops, m_drops);
        end
        checks++;
`endif
    endtask

    initial begin
        bus.cfg_set    = 1'b0;
        bus.cfg_width  = '0;
        bus.cfg_height = '0;
        bus.up_val     = 1'b0;
        bus.up_data    = '0;
        test_reset();
        test_no_cfg();
        test_frame_4x3();
        test_gaps();
        test_midframe_cfg();
        test_zero_cfg();
        test_reset_midframe();
        test_same_edge();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
